// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the I/O configuration receiver: word layout, reset value, FSM states.
package gpio_cfg_pkg;

  localparam int CFG_BITS_DEF = 13;

  localparam int OFS_MGMT_EN       = 0;
  localparam int OFS_OUTENB        = 1;
  localparam int OFS_HOLD_OVERRIDE = 2;
  localparam int OFS_INP_DIS       = 3;
  localparam int OFS_IB_MODE_SEL   = 4;
  localparam int OFS_ANALOG_EN     = 5;
  localparam int OFS_ANALOG_SEL    = 6;
  localparam int OFS_ANALOG_POL    = 7;
  localparam int OFS_SLOW_SEL      = 8;
  localparam int OFS_VTRIP_SEL     = 9;
  localparam int OFS_DM            = 10;
  localparam int DM_W              = 3;

  typedef struct packed {
    logic [DM_W-1:0] dm;
    logic            vtrip_sel;
    logic            slow_sel;
    logic            analog_pol;
    logic            analog_sel;
    logic            analog_en;
    logic            ib_mode_sel;
    logic            inp_dis;
    logic            hold_override;
    logic            outenb;
    logic            mgmt_en;
  } gpio_cfg_t;

  // Management-controlled, output driver off, input enabled (13'h1803).
  localparam gpio_cfg_t CFG_INIT_DEF = '{
    dm: 3'b110, vtrip_sel: 1'b0, slow_sel: 1'b0, analog_pol: 1'b0,
    analog_sel: 1'b0, analog_en: 1'b0, ib_mode_sel: 1'b0, inp_dis: 1'b0,
    hold_override: 1'b0, outenb: 1'b1, mgmt_en: 1'b1
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/gpio_cfg_receiver_if.sv
// Loader stream and configuration outputs of the receiver, seen from loader (master) and receiver (slave).
interface gpio_cfg_if #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS_DEF
);
  logic                         loader_resetn;
  logic                         loader_clock;
  logic                         loader_data;
  logic [NUM_PADS*CFG_BITS-1:0] cfg_out;
  logic                         cfg_commit;
  logic                         busy;
  logic                         frame_err;
  logic                         serial_out;

  modport master (
    output loader_resetn, loader_clock, loader_data,
    input  cfg_out, cfg_commit, busy, frame_err, serial_out
  );

  modport slave (
    input  loader_resetn, loader_clock, loader_data,
    output cfg_out, cfg_commit, busy, frame_err, serial_out
  );
endinterface

// File: rtl/gpio_cfg_sync.sv
// Two-flop synchroniser for one asynchronous loader wire, with rising-edge detect against a third flop.
module gpio_cfg_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);
  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign dout = sync_p1;
  assign rise = sync_p1 & ~sync_p2;
endmodule

// File: rtl/gpio_cfg_receiver.sv
// Serial pad-configuration receiver: shifts the loader stream into a shadow chain and commits whole frames.
// Build option GPIO_CFG_PARITY_EN: one even-parity bit follows each pad word and is checked before commit.
module gpio_cfg_receiver
  import gpio_cfg_pkg::*;
#(
  parameter int                  NUM_PADS = 19,
  parameter int                  CFG_BITS = CFG_BITS_DEF,
  parameter logic [CFG_BITS-1:0] CFG_INIT = CFG_BITS'(CFG_INIT_DEF)
) (
  input  logic       clk,
  input  logic       reset,
  gpio_cfg_if.slave  bus
);

`ifdef GPIO_CFG_PARITY_EN
  localparam int WORD_W = CFG_BITS + 1;
`else
  localparam int WORD_W = CFG_BITS;
`endif
  localparam int                FRAME_BITS = NUM_PADS * WORD_W;
  localparam int                OUT_W      = NUM_PADS * CFG_BITS;
  localparam int                CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_BITS);

  logic rstn_s, clk_s, data_s, clk_rise;
  logic rstn_rise_unused, data_rise_unused, clk_level_unused;

  gpio_cfg_sync u_sync_rstn (
    .clk(clk), .reset(reset), .din(bus.loader_resetn), .dout(rstn_s), .rise(rstn_rise_unused)
  );
  gpio_cfg_sync u_sync_clk (
    .clk(clk), .reset(reset), .din(bus.loader_clock), .dout(clk_s), .rise(clk_rise)
  );
  gpio_cfg_sync u_sync_data (
    .clk(clk), .reset(reset), .din(bus.loader_data), .dout(data_s), .rise(data_rise_unused)
  );
  assign clk_level_unused = clk_s;

  cfg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FRAME_BITS-1:0]  shadow_q;
  logic [OUT_W-1:0]       cfg_q;
  logic                   commit_q, err_q, serial_q;
  logic                   shift_en, load_en, err_set, err_clr, frame_ok;

  // The last word on the wire lands at the bottom of the chain, so pad k sits at slot k.
  function automatic logic [OUT_W-1:0] frame_words(input logic [FRAME_BITS-1:0] sh);
    frame_words = '0;
    for (int k = 0; k < NUM_PADS; k++)
      frame_words[k*CFG_BITS +: CFG_BITS] = sh[k*WORD_W + WORD_W - 1 -: CFG_BITS];
  endfunction

`ifdef GPIO_CFG_PARITY_EN
  function automatic logic parity_ok(input logic [FRAME_BITS-1:0] sh);
    parity_ok = 1'b1;
    for (int k = 0; k < NUM_PADS; k++)
      if (^sh[k*WORD_W +: WORD_W]) parity_ok = 1'b0;
  endfunction
  assign frame_ok = parity_ok(shadow_q);
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    if (!rstn_s) begin
      state_d = ST_IDLE;
      count_d = '0;
      err_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            count_d  = CNT_W'(1);
            state_d  = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Full frame in the shadow: decide the commit one cycle after the final shift.
          if (count_q == FRAME_CNT) begin
            state_d = ST_COMMIT;
            load_en = frame_ok;
            err_set = !frame_ok;
          end else if (clk_rise) begin
            shift_en = 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          count_d = '0;
          state_d = ST_IDLE;
          // A bit arriving now is an overrun but still opens the next frame.
          if (clk_rise) begin
            shift_en = 1'b1;
            err_set  = 1'b1;
            count_d  = CNT_W'(1);
            state_d  = ST_SHIFT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      cfg_q    <= {NUM_PADS{CFG_INIT}};
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      commit_q <= load_en;
      if (shift_en) begin
        shadow_q <= {shadow_q[FRAME_BITS-2:0], data_s};
        serial_q <= shadow_q[FRAME_BITS-1];
      end
      if (load_en) cfg_q <= frame_words(shadow_q);
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.cfg_out    = cfg_q;
  assign bus.cfg_commit = commit_q;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.frame_err  = err_q;
  assign bus.serial_out = serial_q;

endmodule

// File: tb/tb_gpio_cfg_receiver.sv
// Randomised scoreboard bench for gpio_cfg_receiver; decodes the sent bit stream into expected pad words.
module tb_gpio_cfg_receiver;
  import gpio_cfg_pkg::*;

  localparam int NUM_PADS = 19;
  localparam int CFG_BITS = 13;
`ifdef GPIO_CFG_PARITY_EN
  localparam int WORD_W = CFG_BITS + 1;
`else
  localparam int WORD_W = CFG_BITS;
`endif
  localparam int FRAME_BITS = NUM_PADS * WORD_W;
  localparam int OUT_W      = NUM_PADS * CFG_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;

  gpio_cfg_if #(.NUM_PADS(NUM_PADS), .CFG_BITS(CFG_BITS)) bus ();

  gpio_cfg_receiver #(.NUM_PADS(NUM_PADS), .CFG_BITS(CFG_BITS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] model_cfg;
  logic             model_err;
  bit               frame_bits[$];
  bit               stream[$];
  int               n_pushed = 0;
  int               commit_seen = 0;
  int               last_commit_cyc = 0;
  int               last_rise_cyc = 0;
  logic             prev_busy = 1'b0;

  task automatic check_cfg(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference: pad words are read back from the order bits went onto the wire.
  task automatic add_bit(input bit b);
    frame_bits.push_back(b);
    if (frame_bits.size() == FRAME_BITS) begin
      logic [OUT_W-1:0] w;
      bit ok;
      w = '0;
      ok = 1'b1;
      for (int i = 0; i < NUM_PADS; i++) begin
        logic [CFG_BITS-1:0] v;
        int pad;
        pad = NUM_PADS - 1 - i;
        v = '0;
        for (int j = 0; j < CFG_BITS; j++) v = {v[CFG_BITS-2:0], frame_bits[i*WORD_W + j]};
`ifdef GPIO_CFG_PARITY_EN
        if (frame_bits[i*WORD_W + CFG_BITS] != ^v) ok = 1'b0;
`endif
        w[pad*CFG_BITS +: CFG_BITS] = v;
      end
      if (ok) begin
        exp_q.push_back(w);
        n_pushed++;
        model_cfg = w;
      end else begin
        model_err = 1'b1;
      end
      frame_bits.delete();
    end
  endtask

  task automatic make_stream(input logic [OUT_W-1:0] w);
    stream.delete();
    for (int p = NUM_PADS - 1; p >= 0; p--) begin
      logic [CFG_BITS-1:0] v;
      v = w[p*CFG_BITS +: CFG_BITS];
      for (int b = CFG_BITS - 1; b >= 0; b--) stream.push_back(v[b]);
`ifdef GPIO_CFG_PARITY_EN
      stream.push_back(^v);
`endif
    end
  endtask

`ifdef GPIO_CFG_PARITY_EN
  task automatic flip_parity(input int pad);
    int idx;
    idx = (NUM_PADS - 1 - pad) * WORD_W + CFG_BITS;
    stream[idx] = ~stream[idx];
  endtask
`endif

  function automatic logic [OUT_W-1:0] rand_words();
    logic [OUT_W-1:0] w;
    for (int k = 0; k < NUM_PADS; k++) w[k*CFG_BITS +: CFG_BITS] = CFG_BITS'($urandom);
    return w;
  endfunction

  // Each bit: 4 clk low with data set, then 4 clk high.
  task automatic send_bit(input bit b);
    bus.loader_data = b;
    add_bit(b);
    repeat (4) @(negedge clk);
    bus.loader_clock = 1'b1;
    last_rise_cyc = cyc;
    repeat (4) @(negedge clk);
    bus.loader_clock = 1'b0;
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_bit(stream[i]);
  endtask

  task automatic loader_abort();
    bus.loader_resetn = 1'b0;
    repeat (4) @(negedge clk);
    bus.loader_resetn = 1'b1;
    repeat (6) @(negedge clk);
    frame_bits.delete();
    model_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.cfg_commit === 1'b1) begin
      logic [OUT_W-1:0] e;
      commit_seen++;
      last_commit_cyc = cyc;
      check_val("commit_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_cfg("commit_cfg", bus.cfg_out, e);
      end
      check_val("busy_at_commit", int'(bus.busy), 0);
      check_val("busy_before_commit", int'(prev_busy), 1);
    end
    prev_busy = bus.busy;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] w, wa, wb;
    bus.loader_resetn = 1'b1;
    bus.loader_clock  = 1'b0;
    bus.loader_data   = 1'b0;
    model_cfg = {NUM_PADS{13'h1803}};
    model_err = 1'b0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_cfg("reset_cfg", bus.cfg_out, model_cfg);
    check_val("reset_busy", int'(bus.busy), 0);
    check_val("reset_err", int'(bus.frame_err), 0);
    check_val("reset_commit", int'(bus.cfg_commit), 0);
    check_val("reset_serial", int'(bus.serial_out), 0);
    repeat (5) @(negedge clk);

    // Full frame, pad k carries k.
    for (int k = 0; k < NUM_PADS; k++) w[k*CFG_BITS +: CFG_BITS] = CFG_BITS'(k);
    make_stream(w);
    send_range(0, 10);
    check_val("busy_mid_frame", int'(bus.busy), 1);
    send_range(10, FRAME_BITS);
    repeat (3) @(negedge clk);
    check_cfg("frame_k", bus.cfg_out, model_cfg);
    check_val("commit_latency", last_commit_cyc - last_rise_cyc, 4);
    check_val("commit_count_1", commit_seen, n_pushed);
    check_val("busy_after_frame", int'(bus.busy), 0);
    check_val("err_after_frame", int'(bus.frame_err), int'(model_err));

    // Abort a partial frame, then load all 13'h0403.
    make_stream(rand_words());
    send_range(0, 100);
    loader_abort();
    check_cfg("abort_cfg_kept", bus.cfg_out, model_cfg);
    check_val("abort_busy", int'(bus.busy), 0);
    make_stream({NUM_PADS{13'h0403}});
    send_range(0, FRAME_BITS);
    repeat (3) @(negedge clk);
    check_cfg("after_abort_cfg", bus.cfg_out, model_cfg);
    check_val("after_abort_err", int'(bus.frame_err), int'(model_err));

    // Daisy chain: the earliest bits emerge during the last 13 shifts.
    make_stream(rand_words());
    for (int i = 0; i < CFG_BITS; i++) stream.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < FRAME_BITS + CFG_BITS; i++) begin
      send_bit(stream[i]);
      if (i >= FRAME_BITS)
        check_val("serial_out", int'(bus.serial_out), int'(stream[i - FRAME_BITS]));
    end
    loader_abort();
    check_cfg("daisy_cfg", bus.cfg_out, model_cfg);

    // Overrun: first bit of the next frame lands in the commit cycle.
    wa = rand_words();
    wb = rand_words();
    make_stream(wb);
    begin
      bit first_b;
      first_b = stream[0];
      make_stream(wa);
      send_range(0, FRAME_BITS - 1);
      bus.loader_data = stream[FRAME_BITS - 1];
      add_bit(stream[FRAME_BITS - 1]);
      repeat (4) @(negedge clk);
      bus.loader_clock = 1'b1;
      @(negedge clk);
      bus.loader_clock = 1'b0;
      bus.loader_data = first_b;
      add_bit(first_b);
      model_err = 1'b1;
      @(negedge clk);
      bus.loader_clock = 1'b1;
      repeat (4) @(negedge clk);
      bus.loader_clock = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_val("overrun_err", int'(bus.frame_err), int'(model_err));
    check_cfg("overrun_cfg", bus.cfg_out, model_cfg);
    check_val("overrun_busy", int'(bus.busy), 1);
    make_stream(wb);
    send_range(1, FRAME_BITS);
    repeat (3) @(negedge clk);
    check_cfg("after_overrun_cfg", bus.cfg_out, model_cfg);
    check_val("err_sticky", int'(bus.frame_err), int'(model_err));
    loader_abort();
    check_val("err_cleared", int'(bus.frame_err), int'(model_err));

`ifdef GPIO_CFG_PARITY_EN
    w = rand_words();
    make_stream(w);
    flip_parity(5);
    send_range(0, FRAME_BITS);
    repeat (3) @(negedge clk);
    check_cfg("parity_cfg_kept", bus.cfg_out, model_cfg);
    check_val("parity_err", int'(bus.frame_err), int'(model_err));
    make_stream(w);
    send_range(0, FRAME_BITS);
    repeat (3) @(negedge clk);
    check_cfg("parity_fixed_cfg", bus.cfg_out, model_cfg);
`endif

    // Random frames.
    for (int f = 0; f < 2; f++) begin
      make_stream(rand_words());
      send_range(0, FRAME_BITS);
      repeat (3) @(negedge clk);
      check_cfg("random_cfg", bus.cfg_out, model_cfg);
      check_val("random_err", int'(bus.frame_err), int'(model_err));
    end

    repeat (10) @(negedge clk);
    check_val("commit_total", commit_seen, n_pushed);
    check_val("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
